csr_trap_unit: RTL and testbench

//  Machine-mode CSR file and trap sequencer for the SYSTEM opcode; successor to the combinational exception decode.

---
 rtl/csr_trap_unit_pkg.sv | 50 +++++
 rtl/csr_trap_unit_if.sv | 29 ++
 rtl/csr_trap_unit_alu.sv | 39 +++
 rtl/csr_trap_unit.sv | 209 ++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, trap cause codes, mstatus bit positions, FSM states and
// SYSTEM funct3 encodings. Counter addresses are only decoded when
// CSR_COUNTERS_EN is defined.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    // funct12 values of the privileged (funct3 == 000) instructions handled here
    localparam logic [11:0] F12_ECALL = 12'h000;
    localparam logic [11:0] F12_MRET  = 12'h302;

    localparam int unsigned CAUSE_ECALL_M = 11;
    localparam int unsigned CAUSE_ILLEGAL = 2;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_REDIR
    } state_t;

    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_RSVD   = 3'b100,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_t;

    // Addresses with bits [11:10] == 2'b11 are read-only
    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Execute-stage SYSTEM instruction interface: instruction fields in,
// stall / rd write / trap / fetch redirect out.
interface csr_trap_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            i_exception;
    logic [2:0]      i_funct3;
    logic [11:0]     i_funct12;
    logic [4:0]      i_rs1Idx;
    logic [XLEN-1:0] i_rs1Data;
    logic [XLEN-1:0] i_pc;
    logic            o_ready;
    logic            o_rdWrite;
    logic [XLEN-1:0] o_csrRdata;
    logic            o_illegal;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirectPc;

    modport master (
        output i_valid, i_exception, i_funct3, i_funct12, i_rs1Idx, i_rs1Data, i_pc,
        input  o_ready, o_rdWrite, o_csrRdata, o_illegal, o_redirect, o_redirectPc
    );

    modport slave (
        input  i_valid, i_exception, i_funct3, i_funct12, i_rs1Idx, i_rs1Data, i_pc,
        output o_ready, o_rdWrite, o_csrRdata, o_illegal, o_redirect, o_redirectPc
    );
endinterface

// File: rtl/csr_trap_unit_alu.sv
// CSR read-modify-write datapath: W/S/C with register or zero-extended
// immediate source. Set/clear forms with rs1Idx == 0 do not write.
module csr_trap_unit_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] old_val,
    output logic [XLEN-1:0] new_val,
    output logic            wr_en
);
    logic [XLEN-1:0] src;

    // Select operand and compute the new CSR value plus write enable
    always_comb begin
        src     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
        new_val = old_val;
        wr_en   = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                new_val = src;
                wr_en   = 1'b1;
            end
            2'b10: begin
                new_val = old_val | src;
                wr_en   = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_val = old_val & ~src;
                wr_en   = (rs1_idx != 5'd0);
            end
            default: begin
                new_val = old_val;
                wr_en   = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the SYSTEM opcode.
// IDLE accepts an instruction, EXEC performs the CSR access or trap/mret
// bookkeeping, REDIR issues a one-cycle fetch redirect.
// Optional feature: define CSR_COUNTERS_EN to add the 64-bit mcycle counter
// (0xB00, and 0xB80 high half when XLEN == 32).
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input logic             i_clk,
    input logic             i_rst,
    csr_trap_unit_if.slave  bus
);
    localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic [2:0]      f3_q;
    logic [11:0]     f12_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] pc_q;
    logic            mret_q;

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic [XLEN-1:0] alu_wdata;
    logic            alu_we;
    logic            do_ecall, do_mret, do_csr, do_illegal;
    logic            in_exec, csr_wr, trap_take, mret_take;
    logic            accept;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, mcycle_wide;
`endif

    assign accept  = (state_q == ST_IDLE) && bus.i_valid && bus.i_exception;
    assign in_exec = (state_q == ST_EXEC);

    // CSR read mux on the latched address; csr_hit flags implemented CSRs
    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MPP_LO +: 2] = 2'b11;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MIE]  = mie_q;
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (f12_q)
            CSR_MSTATUS:  csr_rdata = mstatus_val;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MHARTID:  csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   csr_rdata = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (XLEN == 32) csr_rdata = XLEN'(mcycle_q[63:32]);
                else            csr_hit   = 1'b0;
            end
`endif
            default:      csr_hit = 1'b0;
        endcase
    end

    csr_trap_unit_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (f3_q),
        .rs1_idx  (rs1_idx_q),
        .rs1_data (rs1_data_q),
        .old_val  (csr_rdata),
        .new_val  (alu_wdata),
        .wr_en    (alu_we)
    );

    // Classify the latched instruction; anything not handled is illegal
    always_comb begin
        do_ecall   = (f3_q == F3_PRIV) && (f12_q == F12_ECALL);
        do_mret    = (f3_q == F3_PRIV) && (f12_q == F12_MRET);
        do_csr     = (f3_q != F3_PRIV) && (f3_q != F3_RSVD) && csr_hit
                     && !(alu_we && is_read_only(f12_q));
        do_illegal = !(do_ecall || do_mret || do_csr);
        csr_wr     = in_exec && do_csr && alu_we;
        trap_take  = in_exec && (do_ecall || do_illegal);
        mret_take  = in_exec && do_mret;
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake / redirect outputs
    always_comb begin
        state_d          = state_q;
        bus.o_ready      = 1'b0;
        bus.o_rdWrite    = 1'b0;
        bus.o_csrRdata   = '0;
        bus.o_illegal    = 1'b0;
        bus.o_redirect   = 1'b0;
        bus.o_redirectPc = '0;
        case (state_q)
            ST_IDLE: begin
                bus.o_ready = 1'b1;
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (do_csr) begin
                    bus.o_rdWrite  = 1'b1;
                    bus.o_csrRdata = csr_rdata;
                    state_d        = ST_IDLE;
                end else begin
                    bus.o_illegal = do_illegal;
                    state_d       = ST_REDIR;
                end
            end
            ST_REDIR: begin
                bus.o_redirect   = 1'b1;
                bus.o_redirectPc = mret_q ? mepc_q : mtvec_q;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the accepted instruction; remember whether REDIR targets mepc
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f3_q       <= '0;
            f12_q      <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            pc_q       <= '0;
            mret_q     <= 1'b0;
        end else begin
            if (accept) begin
                f3_q       <= bus.i_funct3;
                f12_q      <= bus.i_funct12;
                rs1_idx_q  <= bus.i_rs1Idx;
                rs1_data_q <= bus.i_rs1Data;
                pc_q       <= bus.i_pc;
            end
            if (in_exec) mret_q <= do_mret;
        end
    end

    // CSR writes and trap entry / return side effects
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN4;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (csr_wr) begin
            case (f12_q)
                CSR_MSTATUS: begin
                    mie_q  <= alu_wdata[MSTATUS_MIE];
                    mpie_q <= alu_wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= alu_wdata & ALIGN4;
                CSR_MSCRATCH: mscratch_q <= alu_wdata;
                CSR_MEPC:     mepc_q     <= alu_wdata & ALIGN4;
                CSR_MCAUSE:   mcause_q   <= alu_wdata;
                CSR_MTVAL:    mtval_q    <= alu_wdata;
                default: ;
            endcase
        end else if (trap_take) begin
            mepc_q   <= pc_q & ALIGN4;
            mcause_q <= do_ecall ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_ILLEGAL);
            mtval_q  <= '0;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_take) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running cycle counter; a CSR write replaces only the written half
    always_comb begin
        mcycle_wide = 64'(alu_wdata);
        mcycle_d    = mcycle_q + 64'd1;
        if (csr_wr && (f12_q == CSR_MCYCLE)) begin
            if (XLEN == 32) mcycle_d = {mcycle_q[63:32], mcycle_wide[31:0]};
            else            mcycle_d = mcycle_wide;
        end else if (csr_wr && (f12_q == CSR_MCYCLEH)) begin
            mcycle_d = {mcycle_wide[31:0], mcycle_q[31:0]};
        end
    end

    // Cycle counter register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) mcycle_q <= '0;
        else       mcycle_q <= mcycle_d;
    end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed testbench for csr_trap_unit: CSR read-modify-write, ecall/mret,
// illegal decode, reset during redirect, and mcycle when CSR_COUNTERS_EN.
module tb_csr_trap_unit;
    import csr_trap_unit_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    longint cycle = 0;

    logic        r_rdw, r_ill, r_redir, r_busy;
    logic [31:0] r_rdata, r_rpc;
    longint      r_cyc;

    csr_trap_unit_if #(.XLEN(XLEN)) bus ();

    csr_trap_unit #(
        .XLEN        (XLEN),
        .MTVEC_RESET (32'h0000_0203),
        .HART_ID     (32'd5)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction; capture EXEC-cycle outputs and the following cycle's redirect
    task automatic run_op(input logic [2:0] f3, input logic [11:0] f12, input logic [4:0] idx,
                          input logic [31:0] data, input logic [31:0] pc);
        int unsigned guard = 0;
        @(negedge clk);
        while (!bus.o_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.o_ready) check_eq("ready_timeout", 64'd0, 64'd1);
        bus.i_valid     = 1'b1;
        bus.i_exception = 1'b1;
        bus.i_funct3    = f3;
        bus.i_funct12   = f12;
        bus.i_rs1Idx    = idx;
        bus.i_rs1Data   = data;
        bus.i_pc        = pc;
        @(negedge clk);
        r_rdw   = bus.o_rdWrite;
        r_rdata = bus.o_csrRdata;
        r_ill   = bus.o_illegal;
        r_busy  = bus.o_ready;
        r_cyc   = cycle;
        bus.i_valid     = 1'b0;
        bus.i_exception = 1'b0;
        @(negedge clk);
        r_redir = bus.o_redirect;
        r_rpc   = bus.o_redirectPc;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        run_op(3'b010, addr, 5'd0, 32'h0, 32'h0);
        check_eq(tag, r_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] c1, c2;
        longint      t1, tw;

        bus.i_valid = 1'b0; bus.i_exception = 1'b0; bus.i_funct3 = '0; bus.i_funct12 = '0;
        bus.i_rs1Idx = '0; bus.i_rs1Data = '0; bus.i_pc = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", bus.o_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", bus.o_ready, 1);
        check_eq("idle_rdwrite", bus.o_rdWrite, 0);
        check_eq("idle_rdata", bus.o_csrRdata, 0);
        check_eq("idle_illegal", bus.o_illegal, 0);
        check_eq("idle_redirect", bus.o_redirect, 0);
        check_eq("idle_redirpc", bus.o_redirectPc, 0);
        read_chk("rst_mstatus", CSR_MSTATUS, 32'h1800);
        read_chk("rst_mtvec", CSR_MTVEC, 32'h200);
        read_chk("rst_mscratch", CSR_MSCRATCH, 32'h0);
        read_chk("rst_mepc", CSR_MEPC, 32'h0);
        read_chk("rst_mcause", CSR_MCAUSE, 32'h0);
        read_chk("mhartid", CSR_MHARTID, 32'd5);

        // csrrw / csrrs / csrrc / csrrwi on scratch-like registers
        run_op(3'b001, CSR_MSCRATCH, 5'd5, 32'hDEADBEEF, 32'h0);
        check_eq("csrrw_rdw", r_rdw, 1);
        check_eq("csrrw_old", r_rdata, 0);
        check_eq("csrrw_ill", r_ill, 0);
        check_eq("exec_not_ready", r_busy, 0);
        check_eq("csrrw_noredir", r_redir, 0);
        run_op(3'b010, CSR_MSCRATCH, 5'd0, 32'hFFFFFFFF, 32'h0);
        check_eq("csrrs_x0_read", r_rdata, 32'hDEADBEEF);
        read_chk("csrrs_x0_nowrite", CSR_MSCRATCH, 32'hDEADBEEF);
        run_op(3'b011, CSR_MSCRATCH, 5'd3, 32'h0000FFFF, 32'h0);
        check_eq("csrrc_old", r_rdata, 32'hDEADBEEF);
        read_chk("csrrc_new", CSR_MSCRATCH, 32'hDEAD0000);
        run_op(3'b101, CSR_MTVAL, 5'h1F, 32'hFFFFFFFF, 32'h0);
        read_chk("csrrwi_zimm", CSR_MTVAL, 32'h1F);

        // csrrsi MIE, then ecall
        run_op(3'b110, CSR_MSTATUS, 5'd8, 32'h0, 32'h0);
        check_eq("csrrsi_old", r_rdata, 32'h1800);
        read_chk("csrrsi_mie", CSR_MSTATUS, 32'h1808);
        run_op(3'b000, F12_ECALL, 5'd0, 32'h0, 32'h100);
        check_eq("ecall_rdw", r_rdw, 0);
        check_eq("ecall_ill", r_ill, 0);
        check_eq("ecall_redir", r_redir, 1);
        check_eq("ecall_target", r_rpc, 32'h200);
        read_chk("ecall_mepc", CSR_MEPC, 32'h100);
        read_chk("ecall_mcause", CSR_MCAUSE, 32'd11);
        read_chk("ecall_mtval", CSR_MTVAL, 32'h0);
        read_chk("ecall_mstatus", CSR_MSTATUS, 32'h1880);

        // mret
        run_op(3'b000, F12_MRET, 5'd0, 32'h0, 32'h500);
        check_eq("mret_redir", r_redir, 1);
        check_eq("mret_target", r_rpc, 32'h100);
        check_eq("mret_ill", r_ill, 0);
        read_chk("mret_mstatus", CSR_MSTATUS, 32'h1888);

        // illegal cases
        run_op(3'b001, CSR_MHARTID, 5'd1, 32'h1234, 32'h204);
        check_eq("ro_write_ill", r_ill, 1);
        check_eq("ro_write_rdw", r_rdw, 0);
        check_eq("ro_write_redir", r_redir, 1);
        check_eq("ro_write_target", r_rpc, 32'h200);
        read_chk("ill_mcause", CSR_MCAUSE, 32'd2);
        read_chk("ill_mepc", CSR_MEPC, 32'h204);
        read_chk("ill_mstatus", CSR_MSTATUS, 32'h1880);
        run_op(3'b010, CSR_MHARTID, 5'd0, 32'h0, 32'h0);
        check_eq("ro_read_legal", r_ill, 0);
        run_op(3'b100, CSR_MSCRATCH, 5'd0, 32'h0, 32'h208);
        check_eq("f3_100_ill", r_ill, 1);
        read_chk("f3_100_mepc", CSR_MEPC, 32'h208);
        run_op(3'b010, 12'h7C0, 5'd0, 32'h0, 32'h0);
        check_eq("unimpl_ill", r_ill, 1);
        run_op(3'b000, 12'h001, 5'd0, 32'h0, 32'h0);
        check_eq("ebreak_ill", r_ill, 1);
        run_op(3'b000, 12'h105, 5'd0, 32'h0, 32'h0);
        check_eq("wfi_ill", r_ill, 1);

        // alignment masking of mepc / mtvec
        run_op(3'b001, CSR_MEPC, 5'd1, 32'h123, 32'h0);
        read_chk("mepc_align", CSR_MEPC, 32'h120);
        run_op(3'b001, CSR_MTVEC, 5'd1, 32'h303, 32'h0);
        read_chk("mtvec_align", CSR_MTVEC, 32'h300);
        run_op(3'b000, F12_ECALL, 5'd0, 32'h0, 32'h40);
        check_eq("new_mtvec_target", r_rpc, 32'h300);

`ifdef CSR_COUNTERS_EN
        run_op(3'b010, CSR_MCYCLE, 5'd0, 32'h0, 32'h0);
        c1 = r_rdata;
        t1 = r_cyc;
        run_op(3'b010, CSR_MCYCLE, 5'd0, 32'h0, 32'h0);
        c2 = r_rdata;
        check_eq("mcycle_delta", 64'(c2 - c1), 64'(r_cyc - t1));
        read_chk("mcycleh", CSR_MCYCLEH, 32'h0);
        run_op(3'b001, CSR_MCYCLE, 5'd1, 32'h1000, 32'h0);
        tw = r_cyc;
        run_op(3'b010, CSR_MCYCLE, 5'd0, 32'h0, 32'h0);
        check_eq("mcycle_write", r_rdata, 64'(32'h1000 + 32'(r_cyc - tw - 1)));
`else
        run_op(3'b010, CSR_MCYCLE, 5'd0, 32'h0, 32'h0);
        check_eq("mcycle_absent_ill", r_ill, 1);
        run_op(3'b010, CSR_MCYCLEH, 5'd0, 32'h0, 32'h0);
        check_eq("mcycleh_absent_ill", r_ill, 1);
`endif

        // reset while in REDIR drops the redirect
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_exception = 1'b1;
        bus.i_funct3 = 3'b000; bus.i_funct12 = F12_ECALL; bus.i_pc = 32'h80;
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_exception = 1'b0;
        @(posedge clk);
        #1;
        check_eq("redir_before_rst", bus.o_redirect, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_redir_dropped", bus.o_redirect, 0);
        check_eq("rst_state_idle", bus.o_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        read_chk("rst2_mstatus", CSR_MSTATUS, 32'h1800);
        read_chk("rst2_mtvec", CSR_MTVEC, 32'h200);
        read_chk("rst2_mepc", CSR_MEPC, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
